// File: rtl/uparc_pipe_ctrl.sv
`default_nettype none
//============================================================================
// Module   : uparc_pipe_ctrl
// Purpose  : Pipeline interlock and flush controller. Detects load-use and
//            mul/div hazards against the instruction in decode, sequences the
//            nullify/bubble flush on exception entry and counts hold cycles.
// Revision : 1.0  initial release
//============================================================================

`ifndef UPARC_REGNO_WIDTH
`define UPARC_REGNO_WIDTH 5
`endif
`ifndef UPARC_IMDOP_WIDTH
`define UPARC_IMDOP_WIDTH 3
`endif
`ifndef UPARC_IMDOP_IDLE
`define UPARC_IMDOP_IDLE 3'b000
`endif

module uparc_pipe_ctrl #(
    parameter int FLUSH_LEN = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          i_fetch_stall,
    input  logic                          i_mem_stall,
    input  logic [`UPARC_REGNO_WIDTH-1:0] i_dec_rs_no,
    input  logic [`UPARC_REGNO_WIDTH-1:0] i_dec_rt_no,
    input  logic [`UPARC_IMDOP_WIDTH-1:0] i_dec_imd_op,
    input  logic [`UPARC_REGNO_WIDTH-1:0] i_ex_rd_no,
    input  logic                          i_ex_load,
    input  logic                          i_imd_busy,
    input  logic                          i_exc_req,
    input  logic                          i_cnt_clr,
    output logic                          o_hold,
    output logic                          o_bubble,
    output logic                          o_nullify,
    output logic                          o_exc_ack,
    output logic [1:0]                    o_state,
    output logic [CNT_WIDTH-1:0]          o_stall_cnt
);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_IMDW  = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    // The acceptance cycle already nullifies once, so FLUSH covers the rest.
    // FLUSH_LEN=1 means the acceptance cycle alone is the whole flush.
    localparam logic       c_USE_FLUSH  = (FLUSH_LEN >= 2);
    localparam logic [1:0] c_FLUSH_INIT = (FLUSH_LEN >= 2) ? 2'(FLUSH_LEN - 2) : 2'd0;

    logic [1:0]           state_q, state_d;
    logic [1:0]           flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic w_core_stall;
    logic w_ldhaz;
    logic w_imdhaz;
    logic w_exc_take;

    assign w_core_stall = i_fetch_stall | i_mem_stall;

    assign w_ldhaz = i_ex_load && (i_ex_rd_no != '0) &&
                     ((i_ex_rd_no == i_dec_rs_no) || (i_ex_rd_no == i_dec_rt_no));

    assign w_imdhaz = (i_dec_imd_op != `UPARC_IMDOP_IDLE) && i_imd_busy;

    // Exceptions are only taken in RUN/IMDW; FLUSH ignores further requests.
    assign w_exc_take = i_exc_req && !w_core_stall &&
                        ((state_q == c_ST_RUN) || (state_q == c_ST_IMDW));

    // State and flush counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= c_ST_RUN;
            flush_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic; everything freezes during a core stall.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (!w_core_stall) begin
            case (state_q)
                c_ST_RUN: begin
                    if (w_exc_take) begin
                        state_d     = c_USE_FLUSH ? c_ST_FLUSH : c_ST_RUN;
                        flush_cnt_d = c_FLUSH_INIT;
                    end else if (w_imdhaz) begin
                        state_d = c_ST_IMDW;
                    end
                end
                c_ST_IMDW: begin
                    if (w_exc_take) begin
                        state_d     = c_USE_FLUSH ? c_ST_FLUSH : c_ST_RUN;
                        flush_cnt_d = c_FLUSH_INIT;
                    end else if (!i_imd_busy) begin
                        state_d = c_ST_RUN;
                    end
                end
                c_ST_FLUSH: begin
                    if (flush_cnt_q == 2'd0) begin
                        state_d = c_ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d     = c_ST_RUN;
                    flush_cnt_d = 2'd0;
                end
            endcase
        end
    end

    // Pipeline control outputs, combinational from state and inputs.
    always_comb begin
        o_hold    = 1'b0;
        o_bubble  = 1'b0;
        o_nullify = 1'b0;
        o_exc_ack = 1'b0;
        if (!w_core_stall) begin
            case (state_q)
                c_ST_RUN, c_ST_IMDW: begin
                    if (w_exc_take) begin
                        o_exc_ack = 1'b1;
                        o_nullify = 1'b1;
                        o_bubble  = 1'b1;
                    end else if (state_q == c_ST_IMDW) begin
                        o_hold   = i_imd_busy;
                        o_bubble = i_imd_busy;
                    end else begin
                        o_hold   = w_ldhaz | w_imdhaz;
                        o_bubble = w_ldhaz | w_imdhaz;
                    end
                end
                c_ST_FLUSH: begin
                    o_nullify = 1'b1;
                    o_bubble  = 1'b1;
                end
                default: begin
                    o_hold = 1'b0;
                end
            endcase
        end
    end

    // Saturating hold-cycle counter; clear wins and works through stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (!w_core_stall && o_hold && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_state     = state_q;
    assign o_stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: doc/uparc_pipe_ctrl.md
# uparc_pipe_ctrl

Pipeline interlock and flush controller for the Ultiparc integer pipeline. It sits beside the fetch/decode/execute stages and compares the operands of the instruction in decode against the load in execute and the state of the multiply/divide unit. From that it generates the hold, bubble and nullify controls those stages consume. It also sequences the two-cycle pipeline flush on exception entry and keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- FLUSH_LEN, 2: cycles of nullify/bubble issued on exception entry (1..4).
- CNT_WIDTH, 16: stall counter width.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- i_fetch_stall  in  1  fetch stage stalled.
- i_mem_stall  in  1  memory stage stalled.
- i_dec_rs_no  in  `UPARC_REGNO_WIDTH  decoded RS register of instruction in decode.
- i_dec_rt_no  in  `UPARC_REGNO_WIDTH  decoded RT register of instruction in decode.
- i_dec_imd_op  in  `UPARC_IMDOP_WIDTH  decoded mul/div op in decode.
- i_ex_rd_no  in  `UPARC_REGNO_WIDTH  destination of instruction in execute.
- i_ex_load  in  1  instruction in execute is a load.
- i_imd_busy  in  1  mul/div unit computing.
- i_exc_req  in  1  exception request from execute/Cop0.
- i_cnt_clr  in  1  synchronous clear of stall counter.
- o_hold  out  1  freeze fetch and decode registers this cycle.
- o_bubble  out  1  execute latches NOP instead of decode output.
- o_nullify  out  1  decode captures NOP instead of fetched word.
- o_exc_ack  out  1  one-cycle pulse: exception accepted.
- o_state  out  2  FSM state: RUN=0, IMDW=1, FLUSH=2.
- o_stall_cnt  out  CNT_WIDTH  cycles with o_hold=1, saturating.

## Operation
- core_stall = i_fetch_stall | i_mem_stall. While core_stall=1, the FSM, flush counter and stall counter are frozen. Exception acceptance is also blocked. o_hold, o_bubble and o_nullify are driven 0.
- Load-use hazard (combinational, RUN only): ldhaz = i_ex_load & (i_ex_rd_no != 0) & (i_ex_rd_no == i_dec_rs_no | i_ex_rd_no == i_dec_rt_no). On a hazard, o_hold=1 and o_bubble=1 for that cycle.
  - Next cycle execute holds the bubble, so the hazard clears by itself. No state is kept.
- Mul/div interlock: imdhaz = (i_dec_imd_op != `UPARC_IMDOP_IDLE) & i_imd_busy.
  - In RUN, imdhaz gives o_hold=1 and o_bubble=1, and the FSM goes to IMDW.
  - In IMDW, o_hold = o_bubble = i_imd_busy. When i_imd_busy=0, the outputs drop the same cycle and the FSM goes to RUN.
- Exception: i_exc_req & !core_stall in RUN or IMDW has priority over every hazard.
  - That cycle: o_exc_ack=1, o_nullify=1, o_bubble=1, o_hold=0. The FSM goes to FLUSH with flush_cnt = FLUSH_LEN-2.
  - An exception arriving in IMDW aborts the wait.
- FLUSH: o_nullify=1, o_bubble=1, o_hold=0, and i_exc_req is ignored. flush_cnt decrements each unstalled cycle. When flush_cnt=0 at the edge, the FSM goes to RUN.
  - Total nullify cycles including the acceptance cycle is exactly FLUSH_LEN.
  - With FLUSH_LEN=1 there is no FLUSH state: the FSM stays in RUN after acceptance.
- Stall counter: increments on each unstalled cycle with o_hold=1 and saturates at all-ones. i_cnt_clr takes priority over increment, and clears even during core_stall.

## Timing
- Reset values: state RUN, flush_cnt 0, o_stall_cnt 0, o_state 0, o_exc_ack 0.
- In RUN with no request, o_nullify and o_bubble are 0. o_hold follows the combinational hazard terms even during reset.
- o_hold, o_bubble, o_nullify and o_exc_ack are combinational from state and inputs, with zero latency. o_state and o_stall_cnt are registered.
- Load-use costs exactly 1 bubble cycle. Mul/div wait costs the number of cycles i_imd_busy is high while a mul/div op sits in decode.
- If reset is asserted mid-FLUSH or mid-IMDW, the FSM returns to RUN immediately. No ack is re-issued.
- When ldhaz and imdhaz are both set, imdhaz decides the state transition and the outputs are identical.
- If i_exc_req is held high, it is accepted once. It can be accepted again no earlier than the first RUN cycle after FLUSH.

## Test plan
- Load-use: i_ex_load=1, i_ex_rd_no=5, i_dec_rt_no=5 for 1 cycle -> o_hold=o_bubble=1 for that cycle only, o_state stays 0, o_stall_cnt=1. Repeating with i_ex_rd_no=0 gives no hold.
- Mul/div wait: MFLO in decode, i_imd_busy high for 4 cycles -> o_hold high for 4 cycles, o_state=1 for cycles 2-4, back to 0 after busy drops, o_stall_cnt=4.
- Exception in IMDW: i_exc_req pulsed in the 2nd busy cycle (FLUSH_LEN=2) -> o_exc_ack pulse, o_nullify high for 2 cycles, o_hold 0, o_state 1->2->0.
- Stall freeze: i_mem_stall=1 during FLUSH for 3 cycles -> outputs 0, o_state held at 2, flush completes after the stall is released. i_exc_req asserted during the stall is not acknowledged.
- Counter saturation: CNT_WIDTH=4, 20 hold cycles -> o_stall_cnt stops at 15. i_cnt_clr pulse -> 0 the next cycle.
- Async reset mid-FLUSH: nrst low between edges -> o_state=0 and o_stall_cnt=0 immediately, no o_exc_ack after release.
